// File: rtl/pc_branch_alu_pkg.sv
// Shared ALU opcode encoding and PC step size used by the PC/branch/ALU datapath.
package pc_branch_alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational MIPS-style ALU; zero flag is taken from the final result.
module mips_alu_core
  import pc_branch_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_alu_1,
  input  logic [WIDTH-1:0] in_alu_2,
  input  logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  logic lt_signed;
  logic lt_unsigned;

  // Signed compare is done on the operands directly, so A-B overflow cannot corrupt SLT.
  assign lt_signed   = $signed(in_alu_1) < $signed(in_alu_2);
  assign lt_unsigned = in_alu_1 < in_alu_2;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND:  alu_result = in_alu_1 & in_alu_2;
      ALU_OR:   alu_result = in_alu_1 | in_alu_2;
      ALU_ADD:  alu_result = in_alu_1 + in_alu_2;
      ALU_XOR:  alu_result = in_alu_1 ^ in_alu_2;
      ALU_NOR:  alu_result = ~(in_alu_1 | in_alu_2);
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_SUB:  alu_result = in_alu_1 - in_alu_2;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/pc_branch_alu.sv
// Program counter register with +4 incrementer, branch-target adder and the main ALU.
module pc_branch_alu
  import pc_branch_alu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] address_start,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             pc_write,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] in_add_1,
  input  logic [WIDTH-1:0] in_add_2,
  output logic [WIDTH-1:0] out_add,
  input  logic [WIDTH-1:0] in_alu_1,
  input  logic [WIDTH-1:0] in_alu_2,
  input  logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // start wins over pc_write so a (re)launch is never lost to a hazard stall.
  always_comb begin
    pc_d = pc_q;
    if (start) begin
      pc_d = address_start;
    end else if (pc_write) begin
      pc_d = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_q + WIDTH'(PC_INCR);
  assign out_add = in_add_1 + in_add_2;

  mips_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .in_alu_1   (in_alu_1),
    .in_alu_2   (in_alu_2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero)
  );

endmodule

// File: tb/tb_pc_branch_alu.sv
// Self-checking bench: PC sequencing, adder/ALU vector table and a random ALU/adder sweep.
module tb_pc_branch_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] address_start;
  logic [31:0] in_pc;
  logic        pc_write;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] in_add_1;
  logic [31:0] in_add_2;
  logic [31:0] out_add;
  logic [31:0] in_alu_1;
  logic [31:0] in_alu_2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int n_vec;
  int n_err;
  logic [31:0] exp_pc;

  pc_branch_alu dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .address_start (address_start),
    .in_pc         (in_pc),
    .pc_write      (pc_write),
    .pc            (pc),
    .pc_next       (pc_next),
    .in_add_1      (in_add_1),
    .in_add_2      (in_add_2),
    .out_add       (out_add),
    .in_alu_1      (in_alu_1),
    .in_alu_2      (in_alu_2),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .zero          (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } alu_vec_t;

  alu_vec_t tbl[12];

  // Reference ALU written from the opcode definitions using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = (ua + ub) % 64'sd4294967296;
      3'd3: r = ua ^ ub;
      3'd4: r = 64'sd4294967295 - (ua | ub);
      3'd5: r = (ua < ub) ? 1 : 0;
      3'd6: r = (ua - ub + 64'sd4294967296) % 64'sd4294967296;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // One clock edge with PC expectations updated from the priority rules.
  task automatic step;
    if (rst) exp_pc = 32'h0;
    else if (start) exp_pc = address_start;
    else if (pc_write) exp_pc = in_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string name);
    check32({name, ".pc"}, pc, exp_pc);
    check32({name, ".pc_next"}, pc_next, exp_pc + 32'd4);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_pc = 32'h0;
    rst = 1'b1; start = 1'b0; pc_write = 1'b0;
    address_start = 32'h0; in_pc = 32'h0;
    in_add_1 = 32'h0; in_add_2 = 32'h0;
    in_alu_1 = 32'h0; in_alu_2 = 32'h0; alu_ctrl = 3'd0;

    tbl[0]  = '{3'b010, 32'd5,          32'd7,          32'd12,         1'b0};
    tbl[1]  = '{3'b110, 32'd9,          32'd9,          32'd0,          1'b1};
    tbl[2]  = '{3'b000, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
    tbl[3]  = '{3'b001, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFFF0_FFF0,  1'b0};
    tbl[4]  = '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    tbl[5]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    tbl[6]  = '{3'b111, 32'h8000_0000,  32'd1,          32'd1,          1'b0};
    tbl[7]  = '{3'b111, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b1};
    tbl[8]  = '{3'b011, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0};
    tbl[9]  = '{3'b100, 32'hF0F0_0000,  32'h0F0F_0000,  32'h0000_FFFF,  1'b0};
    tbl[10] = '{3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    tbl[11] = '{3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};

    // Reset then hold with no update requests.
    @(negedge clk);
    step();
    rst = 1'b0;
    check_pc("reset");
    for (int i = 0; i < 3; i++) begin
      step();
      check_pc("hold_after_reset");
    end

    // Start load, then a normal PC write.
    start = 1'b1; address_start = 32'h0040_0000;
    step();
    check_pc("start_load");
    start = 1'b0; pc_write = 1'b1; in_pc = 32'h0040_0004;
    step();
    check_pc("pc_write");

    // Stall, then start while stalled, then start beating pc_write.
    pc_write = 1'b0; in_pc = 32'h1234_5678;
    step();
    check_pc("stall");
    start = 1'b1; address_start = 32'h0080_0000;
    step();
    check_pc("start_while_stalled");
    pc_write = 1'b1; in_pc = 32'hDEAD_BEE0; address_start = 32'h0090_0010;
    step();
    check_pc("start_over_write");

    // Reset discards simultaneous start and write.
    rst = 1'b1;
    step();
    check_pc("reset_overrides");
    rst = 1'b0; start = 1'b0;

    // pc_next wraps at the top of the address space.
    in_pc = 32'hFFFF_FFFC;
    step();
    check32("wrap.pc", pc, 32'hFFFF_FFFC);
    check32("wrap.pc_next", pc_next, 32'h0000_0000);
    pc_write = 1'b0;

    // Adder corners.
    in_add_1 = 32'h0000_0010; in_add_2 = 32'h0040_0008; #1;
    check32("add_target", out_add, 32'h0040_0018);
    in_add_1 = 32'hFFFF_FFFC; in_add_2 = 32'd8; #1;
    check32("add_wrap", out_add, 32'h0000_0004);

    // Combinational outputs while reset is held high.
    rst = 1'b1; in_alu_1 = 32'd3; in_alu_2 = 32'd4; alu_ctrl = 3'b010; #1;
    check32("alu_during_rst", alu_result, 32'd7);
    rst = 1'b0;

    // Directed ALU table.
    for (int i = 0; i < 12; i++) begin
      alu_ctrl = tbl[i].op; in_alu_1 = tbl[i].a; in_alu_2 = tbl[i].b;
      #1;
      check32($sformatf("tbl%0d.result", i), alu_result, tbl[i].exp_res);
      check1($sformatf("tbl%0d.zero", i), zero, tbl[i].exp_zero);
    end

    // Random sweep across every opcode.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] er;
      logic [31:0] ea;
      alu_ctrl = 3'(i % 8);
      in_alu_1 = $urandom();
      in_alu_2 = ((i % 16) == 3) ? in_alu_1 : $urandom();
      in_add_1 = $urandom();
      in_add_2 = $urandom();
      #1;
      er = ref_alu(alu_ctrl, in_alu_1, in_alu_2);
      ea = 32'((longint'({32'd0, in_add_1}) + longint'({32'd0, in_add_2})) % 64'sd4294967296);
      n_vec++;
      if (alu_result !== er || zero !== (er == 32'd0) || out_add !== ea) begin
        n_err++;
        $display("FAIL rand%0d: op=%0d a=%h b=%h res=%h exp=%h zero=%b add=%h exp_add=%h",
                 i, alu_ctrl, in_alu_1, in_alu_2, alu_result, er, zero, out_add, ea);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_branch_alu.md
PC_BRANCH_ALU -- requirements
Module: pc_branch_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; all other widths below assume 32.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  load address_start into PC.
REQ-007 address_start  input  32  starting PC value.
REQ-008 in_pc  input  32  next-PC candidate (branch/jump/sequential mux result).
REQ-009 pc_write  input  1  PC update enable; 0 = stall (hazard unit).
REQ-010 pc  output  32  current PC, drives instruction memory address.
REQ-011 pc_next  output  32  pc + 4.
REQ-012 in_add_1, in_add_2  input  32 each  branch-target adder operands (shifted offset, PC+4).
REQ-013 out_add  output  32  in_add_1 + in_add_2.
REQ-014 in_alu_1, in_alu_2  input  32 each  ALU operands A, B.
REQ-015 alu_ctrl  input  3  ALU operation select.
REQ-016 alu_result  output  32  ALU result.
REQ-017 zero  output  1  1 when alu_result == 0.

Function
REQ-018 PC register update priority each rising edge: rst > start > pc_write > hold.
REQ-019 start=1 (rst=0): pc <= address_start regardless of pc_write.
REQ-020 pc_write=1, start=0: pc <= in_pc; pc_write=0: pc holds.
REQ-021 pc_next SHALL be combinational pc + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 out_add SHALL be combinational, unsigned modulo-2^32 sum; carry discarded; no internal shift.
REQ-023 ALU combinational, zero latency; encodings: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB (A-B), 111 SLT (signed A<B -> 1 else 0), 101 SLTU (unsigned A<B).
REQ-024 ADD/SUB SHALL wrap modulo 2^32; no overflow flag, no exception.
REQ-025 SLT SHALL compare two's-complement correctly including overflow cases (e.g. A=32'h8000_0000, B=1 -> 1).
REQ-026 zero SHALL derive from final alu_result for every opcode (BEQ uses SUB).
REQ-027 Combinational outputs (out_add, alu_result, zero) SHALL NOT depend on rst or clk.

Reset
REQ-028 rst=1 at rising edge: pc <= RESET_PC, hence pc_next = RESET_PC + 4; overrides start and pc_write.
REQ-029 Reset mid-operation SHALL discard any pending PC update in that cycle.
REQ-030 No other state exists; pc is X-free after first reset edge.

Structure
REQ-031 Shared package pc_branch_alu_pkg SHALL hold the alu_ctrl encoding constants/enum and PC increment constant (4).
REQ-032 ALU SHALL be one sub-module, mips_alu_core (in_alu_1, in_alu_2, alu_ctrl -> alu_result, zero); PC register and adder inline.

Verification
REQ-033 rst=1 one edge, then rst=0, start=0, pc_write=0 -> pc=0, pc_next=4, held over 3 cycles.
REQ-034 start=1, address_start=32'h0040_0000 -> pc=32'h0040_0000, pc_next=32'h0040_0004; then pc_write=1, in_pc=32'h0040_0004 -> pc=32'h0040_0004.
REQ-035 pc_write=0 with in_pc=32'h1234_5678 -> pc unchanged; start=1 and pc_write=0 same edge -> pc=address_start.
REQ-036 in_add_1=32'h0000_0010, in_add_2=32'h0040_0008 -> out_add=32'h0040_0018; 32'hFFFF_FFFC + 8 -> 32'h0000_0004.
REQ-037 ALU: ADD 5+7=12 zero=0; SUB 9-9=0 zero=1; AND F0F0_F0F0&0FF0_0FF0=00F0_00F0; OR same -> FFF0_FFF0; SLT FFFF_FFFF(-1)<1 -> 1, SLTU -> 0.
REQ-038 Random ALU/adder sweep (10k vectors, all alu_ctrl codes) vs reference model -> zero mismatches.
